in_ram_packer: RTL and testbench
================================

Name: in_ram_packer

Overview:
- Upstream write-side feeder for the matrix input RAM (160-bit x 64-word, registered-read dual-port).
- Accepts a valid/ready stream of 16-bit matrix elements and packs 10 elements per 160-bit word.
- Drives the RAM write port with sequentially incrementing addresses and reports frame completion to the matrix controller.

Parameters:
- DWIDTH, 160, RAM word width in bits.
- AWIDTH, 6, RAM address width.
- WORDS, 64, words per frame; the last address written in a full frame is WORDS-1.
- EWIDTH, 16, element width; DWIDTH/EWIDTH must be an integer.
- ELEMS, DWIDTH/EWIDTH (10), elements per word.

Ports:
- clk  in  1  Single clock; all logic is on the rising edge.
- rst_n  in  1  Asynchronous active-low reset.
- start  in  1  One-cycle pulse that begins a frame. Honoured only in IDLE.
- s_valid  in  1  Input element valid.
- s_ready  out  1  Input element ready.
- s_data  in  EWIDTH  Input element.
- s_last  in  1  Marks the final element of a frame; qualified by the handshake.
- ram_wen  out  1  RAM write enable, registered.
- ram_waddr  out  AWIDTH  RAM write address, registered.
- ram_wdat  out  DWIDTH  RAM write data, registered.
- busy  out  1  High in FILL and FLUSH.
- frame_done  out  1  One-cycle pulse at the end of a frame.
- words_written  out  AWIDTH+1  Words written in the last or current frame (0..WORDS).

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE.
  - Cleared to zero: s_ready, ram_wen, ram_waddr, ram_wdat, busy, frame_done, words_written.
  - Also cleared: element index, word address counter, pack register.
- Handshake: an element is accepted on a rising edge where s_valid && s_ready.
  - s_ready is combinational from state only: 1 in FILL, else 0.
  - s_ready never depends on s_valid.
- Packing: element index k (0..ELEMS-1) is written to pack bits [EWIDTH*k+EWIDTH-1 : EWIDTH*k]. Element 0 occupies the LSBs.
- States:
  - IDLE: on start, clear the address counter, element index, pack register and words_written, then go to FILL. frame_done=0.
  - FILL, accept with k<ELEMS-1 and s_last=0: store the element, k++.
  - FILL, accept with k==ELEMS-1 or s_last=1: on the next edge, ram_wen=1, ram_wdat=pack with the new element merged, ram_waddr=address counter.
    - Unfilled element slots are zero.
    - Increment the address counter and words_written; set k=0; clear pack.
    - If s_last=1 or the address counter equals WORDS-1, go to FLUSH; otherwise stay in FILL.
  - FLUSH: one cycle. ram_wen=0, frame_done=1, s_ready=0. Next state is IDLE.
- Latency: exactly 1 cycle from the completing handshake edge to ram_wen high. ram_wen is a single-cycle pulse per word.
- Maximum throughput is 1 element per cycle, so back-to-back words give ram_wen high for 1 cycle every 10 cycles.
- Full frame: after the 640th element (64 words) the block ends the frame without needing s_last.
  - Further s_valid is not accepted, because s_ready=0.
  - s_last on the 640th element has the same effect.
- Short frame: s_last before 640 elements flushes a zero-padded partial word. words_written gives the count.
- s_last on element index 0: writes a word with only slot 0 populated.
- start while busy: ignored, with no effect on counters.
- start in the same cycle as FLUSH: ignored. A new frame starts only from IDLE.
- words_written holds its value through IDLE until the next start.
- Reset mid-frame: returns to IDLE immediately; a pending ram_wen is dropped. No partial word is written after reset deasserts.
- The address never wraps within a frame. The counter width is AWIDTH+1 internally, so WORDS is detectable.

Decomposition:
- Shared package (matrix_pkg) holds:
  - constants DWIDTH=160, AWIDTH=6, WORDS=64, EWIDTH=16, ELEMS=10;
  - state encoding IDLE/FILL/FLUSH.
- No sub-module. The block is a single FSM plus counters and the pack register, and instantiates no RAM.
- The top level connects ram_* to the RAM write port.

Test Plan:
- Reset then start, 640 elements with s_data = index (0..639), s_valid held high:
  - 64 ram_wen pulses at addresses 0..63;
  - word 0 = {16'd9,...,16'd1,16'd0};
  - word 63 holds elements 630..639;
  - frame_done pulses 1 cycle after the last write; words_written=64; s_ready=0 afterwards.
- Start, 23 elements (values 100..122) with s_last on element 22:
  - writes at addr 0 and 1, then a third write at addr 2 with slots 0..2 = 120,121,122 and slots 3..9 = 0;
  - words_written=3; frame_done=1.
- Start, then s_valid toggling 1/0 every cycle for 20 elements:
  - exactly 2 writes at addr 0 and 1, with correct packing and no duplicated or dropped element;
  - each ram_wen comes exactly 1 cycle after the 10th and 20th accepted handshake.
- Start pulse while in FILL after 5 elements:
  - element index and address are not reset;
  - after 5 more elements, word 0 holds all 10 elements at addr 0.
- rst_n asserted for 1 cycle after 15 elements (mid-word 1):
  - all outputs are 0 immediately, with no write at addr 1;
  - a new start then 10 elements writes at addr 0.
- Start, single element 16'hABCD with s_last:
  - one write at addr 0, ram_wdat = 160'h...0000ABCD;
  - words_written=1; frame_done pulses once.

Source files
------------

// File: rtl/in_ram_packer_pkg.sv
// Shared constants and state encoding for the matrix input RAM feeder.
// Pure declarations: no logic, no latency, no flow control.
package matrix_pkg;

  localparam int DWIDTH = 160;
  localparam int AWIDTH = 6;
  localparam int WORDS  = 64;
  localparam int EWIDTH = 16;
  localparam int ELEMS  = DWIDTH / EWIDTH;
  localparam int KW     = $clog2(ELEMS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    FLUSH = 2'd2
  } state_e;

endpackage

// File: rtl/in_ram_packer_if.sv
// Element stream in, RAM write port out; slave is the packer, master the producer/RAM side.
// Signal bundle only: no registers and no latency; s_ready is driven by the packer.
interface in_ram_packer_if;
  import matrix_pkg::*;

  logic              s_valid;
  logic              s_ready;
  logic [EWIDTH-1:0] s_data;
  logic              s_last;
  logic              ram_wen;
  logic [AWIDTH-1:0] ram_waddr;
  logic [DWIDTH-1:0] ram_wdat;

  modport slave (
    input  s_valid, s_data, s_last,
    output s_ready, ram_wen, ram_waddr, ram_wdat
  );

  modport master (
    output s_valid, s_data, s_last,
    input  s_ready, ram_wen, ram_waddr, ram_wdat
  );

endinterface

// File: rtl/in_ram_packer.sv
// Packs 16-bit elements ten per word into sequential RAM writes, 1 cycle handshake-to-write.
// s_ready is high only while filling; frame_done pulses one cycle after the final write.
module in_ram_packer
  import matrix_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  in_ram_packer_if.slave    bus,
  output logic              busy,
  output logic              frame_done,
  output logic [AWIDTH:0]   words_written
);

  state_e            state_q, state_d;
  logic [KW-1:0]     k_q;
  logic [AWIDTH:0]   addr_q;
  logic [DWIDTH-1:0] pack_q;
  logic [DWIDTH-1:0] pack_merged;
  logic              ram_wen_q;
  logic [AWIDTH-1:0] ram_waddr_q;
  logic [DWIDTH-1:0] ram_wdat_q;
  logic              frame_done_q;

  logic accept;
  logic word_done;
  logic frame_end;

  assign bus.s_ready   = (state_q == FILL);
  assign bus.ram_wen   = ram_wen_q;
  assign bus.ram_waddr = ram_waddr_q;
  assign bus.ram_wdat  = ram_wdat_q;
  assign busy          = (state_q != IDLE);
  assign frame_done    = frame_done_q;
  // The address counter doubles as the word count: both clear on start and step per write.
  assign words_written = addr_q;

  assign accept    = bus.s_valid && bus.s_ready;
  assign word_done = accept && ((k_q == KW'(ELEMS - 1)) || bus.s_last);
  assign frame_end = word_done && (bus.s_last || (addr_q == (AWIDTH + 1)'(WORDS - 1)));

  always_comb begin
    pack_merged = pack_q;
    pack_merged[int'(k_q) * EWIDTH +: EWIDTH] = bus.s_data;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = FILL;
      FILL:    if (frame_end) state_d = FLUSH;
      FLUSH:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k_q          <= '0;
      addr_q       <= '0;
      pack_q       <= '0;
      ram_wen_q    <= 1'b0;
      ram_waddr_q  <= '0;
      ram_wdat_q   <= '0;
      frame_done_q <= 1'b0;
    end else begin
      ram_wen_q    <= 1'b0;
      frame_done_q <= (state_q == FLUSH);
      if (state_q == IDLE && start) begin
        k_q    <= '0;
        addr_q <= '0;
        pack_q <= '0;
      end else if (word_done) begin
        // Unused slots stay zero because pack_q is cleared after every write.
        ram_wen_q   <= 1'b1;
        ram_waddr_q <= addr_q[AWIDTH-1:0];
        ram_wdat_q  <= pack_merged;
        addr_q      <= addr_q + (AWIDTH + 1)'(1);
        k_q         <= '0;
        pack_q      <= '0;
      end else if (accept) begin
        pack_q <= pack_merged;
        k_q    <= k_q + KW'(1);
      end
    end
  end

endmodule

// File: tb/tb_in_ram_packer.sv
// Randomized scoreboard bench for in_ram_packer against a queue-based packing model.
module tb_in_ram_packer;
  import matrix_pkg::*;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            start;
  logic            busy;
  logic            frame_done;
  logic [AWIDTH:0] words_written;

  in_ram_packer_if ifc ();

  in_ram_packer dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .bus           (ifc),
    .busy          (busy),
    .frame_done    (frame_done),
    .words_written (words_written)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int vectors    = 0;
  int miscompares = 0;

  typedef struct {
    int                addr;
    logic [DWIDTH-1:0] dat;
    int                cyc;
  } wr_t;

  typedef struct {
    int cyc;
    int ww;
  } done_t;

  wr_t               exp_wr[$];
  done_t             exp_done[$];
  logic [EWIDTH-1:0] cur[$];
  int                m_words  = 0;
  bit                m_active = 1'b0;

  task automatic chk(input string name, input logic [DWIDTH-1:0] act, input logic [DWIDTH-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: a frame is a list of elements cut into groups of ELEMS.
  function automatic void model_start();
    if (!m_active) begin
      m_active = 1'b1;
      m_words  = 0;
      cur.delete();
    end
  endfunction

  function automatic void model_reset();
    m_active = 1'b0;
    m_words  = 0;
    cur.delete();
  endfunction

  function automatic void model_accept(input logic [EWIDTH-1:0] d, input logic l, input int h);
    wr_t   w;
    done_t dn;
    cur.push_back(d);
    if (cur.size() == ELEMS || l) begin
      w.dat = '0;
      foreach (cur[i])
        w.dat = w.dat | ({{(DWIDTH-EWIDTH){1'b0}}, cur[i]} << (EWIDTH * i));
      w.addr = m_words;
      w.cyc  = h;
      exp_wr.push_back(w);
      m_words++;
      cur.delete();
      if (l || m_words == WORDS) begin
        dn.cyc = h + 1;
        dn.ww  = m_words;
        exp_done.push_back(dn);
        m_active = 1'b0;
      end
    end
  endfunction

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (ifc.ram_wen) begin
        if (exp_wr.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_write: got addr %0d data %0h, expected no write", ifc.ram_waddr, ifc.ram_wdat);
        end else begin
          wr_t w;
          w = exp_wr.pop_front();
          chk("waddr", DWIDTH'(ifc.ram_waddr), DWIDTH'(w.addr));
          chk("wdat", ifc.ram_wdat, w.dat);
          chk("wcycle", DWIDTH'(cyc), DWIDTH'(w.cyc));
        end
      end
      if (frame_done) begin
        if (exp_done.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_frame_done: got pulse at cycle %0d, expected none", cyc);
        end else begin
          done_t dn;
          dn = exp_done.pop_front();
          chk("done_cycle", DWIDTH'(cyc), DWIDTH'(dn.cyc));
          chk("done_words", DWIDTH'(words_written), DWIDTH'(dn.ww));
        end
      end
    end
  end

  task automatic do_start();
    model_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic gap_cycles(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic send(input logic [EWIDTH-1:0] d, input logic l, input int gap);
    bit got;
    got = 1'b0;
    gap_cycles(gap);
    ifc.s_valid = 1'b1;
    ifc.s_data  = d;
    ifc.s_last  = l;
    for (int t = 0; t < 200 && !got; t++) begin
      @(negedge clk);
      if (ifc.s_ready) begin
        got = 1'b1;
        model_accept(d, l, cyc + 1);
      end
      @(posedge clk); #1;
    end
    ifc.s_valid = 1'b0;
    ifc.s_last  = 1'b0;
    if (!got) begin
      vectors++;
      miscompares++;
      $display("FAIL handshake_timeout: got s_ready=0 for 200 cycles, expected acceptance");
    end
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int t = 0; t < 2000 && !ok; t++) begin
      @(negedge clk);
      if (!busy && exp_wr.size() == 0 && exp_done.size() == 0) ok = 1'b1;
    end
    @(posedge clk); #1;
    if (!ok) begin
      vectors++;
      miscompares++;
      $display("FAIL drain_timeout: got busy=%0d pending writes=%0d pending done=%0d, expected all 0",
               busy, exp_wr.size(), exp_done.size());
    end
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_s_ready", DWIDTH'(ifc.s_ready), '0);
    chk("rst_ram_wen", DWIDTH'(ifc.ram_wen), '0);
    chk("rst_ram_waddr", DWIDTH'(ifc.ram_waddr), '0);
    chk("rst_ram_wdat", ifc.ram_wdat, '0);
    chk("rst_busy", DWIDTH'(busy), '0);
    chk("rst_frame_done", DWIDTH'(frame_done), '0);
    chk("rst_words_written", DWIDTH'(words_written), '0);
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    gap_cycles(1);
  endtask

  initial begin
    int len;
    rst_n       = 1'b0;
    start       = 1'b0;
    ifc.s_valid = 1'b0;
    ifc.s_data  = '0;
    ifc.s_last  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    pulse_reset();

    // Full frame, ends on the address limit with no s_last.
    do_start();
    for (int i = 0; i < 640; i++) send(EWIDTH'(i), 1'b0, 0);
    wait_idle();
    chk("full_words_written", DWIDTH'(words_written), DWIDTH'(64));
    ifc.s_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("full_s_ready_low", DWIDTH'(ifc.s_ready), '0);
    end
    @(posedge clk); #1;
    ifc.s_valid = 1'b0;

    // Short frame: 23 elements, zero-padded third word.
    do_start();
    for (int i = 0; i < 23; i++) send(EWIDTH'(100 + i), (i == 22), 0);
    wait_idle();
    chk("short_words_written", DWIDTH'(words_written), DWIDTH'(3));

    // Valid toggling every cycle for 20 elements, then reset out of FILL.
    do_start();
    for (int i = 0; i < 20; i++) send(EWIDTH'($urandom), 1'b0, (i == 0) ? 0 : 1);
    gap_cycles(3);
    chk("toggle_pending_writes", DWIDTH'(exp_wr.size()), '0);
    chk("toggle_busy", DWIDTH'(busy), DWIDTH'(1));
    pulse_reset();

    // Start while filling must not disturb index or address.
    do_start();
    for (int i = 0; i < 5; i++) send(EWIDTH'(200 + i), 1'b0, 0);
    do_start();
    for (int i = 5; i < 10; i++) send(EWIDTH'(200 + i), 1'b0, 0);
    send(EWIDTH'(16'h5a5a), 1'b1, 0);
    wait_idle();
    chk("restart_words_written", DWIDTH'(words_written), DWIDTH'(2));

    // Reset mid-word 1 drops the partial word.
    do_start();
    for (int i = 0; i < 15; i++) send(EWIDTH'($urandom), 1'b0, 0);
    pulse_reset();
    do_start();
    for (int i = 0; i < 10; i++) send(EWIDTH'($urandom), 1'b0, 0);
    send(EWIDTH'($urandom), 1'b1, 0);
    wait_idle();

    // Single element with s_last.
    do_start();
    send(EWIDTH'(16'hABCD), 1'b1, 0);
    wait_idle();
    chk("single_words_written", DWIDTH'(words_written), DWIDTH'(1));
    gap_cycles(5);
    chk("idle_hold_words_written", DWIDTH'(words_written), DWIDTH'(1));

    // Random frames with random gaps.
    for (int f = 0; f < 6; f++) begin
      len = $urandom_range(1, 120);
      do_start();
      for (int i = 0; i < len; i++)
        send(EWIDTH'($urandom), (i == len - 1), $urandom_range(0, 2));
      wait_idle();
      chk("rand_words_written", DWIDTH'(words_written), DWIDTH'((len + ELEMS - 1) / ELEMS));
    end

    gap_cycles(4);
    chk("final_pending_writes", DWIDTH'(exp_wr.size()), '0);
    chk("final_pending_done", DWIDTH'(exp_done.size()), '0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
